sdram_wr_arbiter: RTL and testbench

- Sequences and shares the single f2h_sdram0 write port (Avalon-MM burst master into HPS SDRAM) between two video stream writers, e.g. the two exposure channels of the HDR pipeline.
- Each writer owns a FWFT FIFO and a frame buffer region in SDRAM.
- Round-robin grants one fixed-length burst at a time.
- Keeps a per-requester frame offset pointer that wraps at frame end.
- Sits between the stream FIFOs and the HPS interface wrapper.

---
 rtl/sdram_wr_arbiter_if.sv | 31 +++
 rtl/sdram_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_sdram_wr_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_wr_arbiter_if.sv
// rtl/sdram_wr_arbiter_if.sv - Avalon-MM burst write port between the arbiter and the HPS SDRAM wrapper
interface sdram_wr_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 29,
    parameter int BCNT_W = 8
);
    logic [ADDR_W-1:0]   avm_address;
    logic [BCNT_W-1:0]   avm_burstcount;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;

    modport master (
        output avm_address,
        output avm_burstcount,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_burstcount,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest
    );
endinterface

// File: rtl/sdram_wr_arbiter.sv
// rtl/sdram_wr_arbiter.sv - round-robin fixed-length burst arbiter for two stream writers sharing one SDRAM write port
module sdram_wr_arbiter #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 29,
    parameter int                BCNT_W      = 8,
    parameter int                BURST_LEN   = 16,
    parameter int                FRAME_WORDS = 76800,
    parameter logic [ADDR_W-1:0] BASE0       = 29'h0100_0000,
    parameter logic [ADDR_W-1:0] BASE1       = 29'h0108_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [1:0]        rq_req,
    input  logic [DATA_W-1:0] rq_data0,
    input  logic [DATA_W-1:0] rq_data1,
    output logic [1:0]        rq_rd,
    input  logic [1:0]        sof,
    output logic [1:0]        frame_done,
    output logic              busy,
    sdram_wr_arbiter_if.master avm
);

    localparam logic [BCNT_W-1:0] BURST_BC  = BCNT_W'(BURST_LEN);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_nxt;
    logic                    owner;
    logic                    rr_ptr;
    logic [BCNT_W-1:0]       beat_cnt;
    logic [1:0][ADDR_W-1:0]  offset;
    logic [1:0]              sof_pend;
    logic [ADDR_W-1:0]       addr_q;
    logic [BCNT_W-1:0]       bcnt_q;

    logic                    accept;
    logic                    last_beat;
    logic                    grant_valid;
    logic                    grant_g;
    logic [ADDR_W-1:0]       grant_off;
    logic [ADDR_W-1:0]       grant_base;
    logic [1:0]              owner_vec;

    // rr_ptr names the requester that wins a tie, so clearing it gives requester 0 the first grant
    assign grant_valid = (state == IDLE) && en && (|rq_req);
    assign grant_g     = (&rq_req) ? rr_ptr : rq_req[1];
    assign grant_off   = sof[grant_g] ? '0 : offset[grant_g];
    assign grant_base  = grant_g ? BASE1 : BASE0;

    assign accept      = avm.avm_write && !avm.avm_waitrequest;
    assign last_beat   = accept && (beat_cnt == LAST_BEAT);
    assign owner_vec   = (state == BURST) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    assign avm.avm_write      = (state == BURST);
    assign avm.avm_address    = addr_q;
    assign avm.avm_burstcount = bcnt_q;
    assign avm.avm_writedata  = owner ? rq_data1 : rq_data0;
    assign avm.avm_byteenable = '1;
    assign busy               = (state == BURST);
    assign rq_rd              = accept ? owner_vec : 2'b00;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = BURST;
            BURST:   if (last_beat)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            beat_cnt   <= '0;
            offset     <= '0;
            sof_pend   <= 2'b00;
            addr_q     <= '0;
            bcnt_q     <= '0;
            frame_done <= 2'b00;
        end else begin
            state      <= state_nxt;
            frame_done <= 2'b00;

            if (grant_valid) begin
                owner    <= grant_g;
                rr_ptr   <= ~grant_g;
                beat_cnt <= '0;
                addr_q   <= grant_base + grant_off;
                bcnt_q   <= BURST_BC;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            // a start-of-frame seen during the owner's burst wins over the end-of-burst advance
            for (int i = 0; i < 2; i++) begin
                if (owner_vec[i]) begin
                    if (last_beat) begin
                        sof_pend[i] <= 1'b0;
                        if (sof_pend[i] || sof[i]) begin
                            offset[i] <= '0;
                        end else if (offset[i] + BURST_INC == FRAME_END) begin
                            offset[i]     <= '0;
                            frame_done[i] <= 1'b1;
                        end else begin
                            offset[i] <= offset[i] + BURST_INC;
                        end
                    end else if (sof[i]) begin
                        sof_pend[i] <= 1'b1;
                    end
                end else if (sof[i]) begin
                    offset[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_wr_arbiter.sv
// tb/tb_sdram_wr_arbiter.sv - directed self-checking bench for sdram_wr_arbiter
module tb_sdram_wr_arbiter;

    localparam int DW = 64;
    localparam int AW = 29;
    localparam int BW = 8;
    localparam int BL = 16;
    localparam int FW = 32;
    localparam logic [AW-1:0] B0 = 29'h0100_0000;
    localparam logic [AW-1:0] B1 = 29'h0108_0000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    rq_req = 2'b00;
    logic [1:0]    sof = 2'b00;
    logic [DW-1:0] rq_data0;
    logic [DW-1:0] rq_data1;
    logic [1:0]    rq_rd;
    logic [1:0]    frame_done;
    logic          busy;

    int pop0 = 0;
    int pop1 = 0;
    int compared = 0;
    int mismatched = 0;
    int wcyc;
    int ncyc;

    sdram_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .BCNT_W(BW)) bus ();

    sdram_wr_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .BCNT_W(BW), .BURST_LEN(BL),
        .FRAME_WORDS(FW), .BASE0(B0), .BASE1(B1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .rq_req(rq_req),
        .rq_data0(rq_data0), .rq_data1(rq_data1), .rq_rd(rq_rd),
        .sof(sof), .frame_done(frame_done), .busy(busy), .avm(bus)
    );

    always #5 clk = ~clk;

    // FWFT FIFO heads: each pop exposes the next sequence number
    always @(posedge clk) begin
        if (rq_rd[0]) pop0 <= pop0 + 1;
        if (rq_rd[1]) pop1 <= pop1 + 1;
    end
    assign rq_data0 = {32'hA0A0_0000, pop0[31:0]};
    assign rq_data1 = {32'hB1B1_0000, pop1[31:0]};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic burst(input string tag, input bit g, input logic [AW-1:0] addr,
                         input logic [15:0] stall, input int sof_beat, input logic [1:0] sof_val,
                         input int en_beat, output int wait_cyc, output int cycles);
        int          beat;
        bit          stalled;
        bit          wr;
        int          start;
        logic [31:0] tagw;
        beat = 0;
        stalled = 1'b0;
        wait_cyc = 0;
        cycles = 0;
        while (!bus.avm_write && wait_cyc < 20) begin
            @(negedge clk); #1;
            wait_cyc++;
        end
        check({tag, " start"}, 64'(bus.avm_write), 64'd1);
        if (!bus.avm_write) return;
        check({tag, " addr"}, 64'(bus.avm_address), 64'(addr));
        check({tag, " bcnt"}, 64'(bus.avm_burstcount), 64'(BL));
        start = g ? pop1 : pop0;
        tagw  = g ? 32'hB1B1_0000 : 32'hA0A0_0000;
        while (beat < BL && cycles < 40) begin
            wr = stall[beat] && !stalled;
            bus.avm_waitrequest = wr;
            sof = (beat == sof_beat && !stalled) ? sof_val : 2'b00;
            if (beat == en_beat) en = 1'b0;
            #1;
            check({tag, " write"}, 64'(bus.avm_write), 64'd1);
            check({tag, " busy"}, 64'(busy), 64'd1);
            check({tag, " hold addr"}, 64'(bus.avm_address), 64'(addr));
            check({tag, " rq_rd"}, 64'(rq_rd), wr ? 64'd0 : (g ? 64'd2 : 64'd1));
            if (!wr) check({tag, " data"}, bus.avm_writedata, {tagw, 32'(start + beat)});
            if (wr) stalled = 1'b1;
            else begin
                stalled = 1'b0;
                beat++;
            end
            cycles++;
            @(negedge clk); #1;
        end
        sof = 2'b00;
        bus.avm_waitrequest = 1'b0;
        check({tag, " end write"}, 64'(bus.avm_write), 64'd0);
        check({tag, " end busy"}, 64'(busy), 64'd0);
        check({tag, " pops"}, 64'((g ? pop1 : pop0) - start), 64'(BL));
    endtask

    initial begin
        bus.avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst write", 64'(bus.avm_write), 64'd0);
        check("rst addr", 64'(bus.avm_address), 64'd0);
        check("rst bcnt", 64'(bus.avm_burstcount), 64'd0);
        check("rst rq_rd", 64'(rq_rd), 64'd0);
        check("rst frame_done", 64'(frame_done), 64'd0);
        check("rst busy", 64'(busy), 64'd0);

        reset_n = 1'b1;
        en = 1'b1;
        @(negedge clk); #1;
        rq_req = 2'b01;

        burst("single", 1'b0, B0, 16'h0000, -1, 2'b00, -1, wcyc, ncyc);
        check("single latency", 64'(wcyc), 64'd1);
        check("single cycles", 64'(ncyc), 64'd16);
        check("single no done", 64'(frame_done), 64'd0);

        burst("stall", 1'b0, B0 + 16, 16'h0038, -1, 2'b00, -1, wcyc, ncyc);
        check("stall latency", 64'(wcyc), 64'd1);
        check("stall cycles", 64'(ncyc), 64'd19);
        check("wrap done", 64'(frame_done), 64'd1);
        @(negedge clk); #1;
        check("wrap done pulse", 64'(frame_done), 64'd0);

        burst("wrapped", 1'b0, B0, 16'h0000, -1, 2'b00, -1, wcyc, ncyc);
        check("wrapped no done", 64'(frame_done), 64'd0);

        rq_req = 2'b11;
        burst("rr a", 1'b1, B1, 16'h0000, -1, 2'b00, -1, wcyc, ncyc);
        burst("rr b", 1'b0, B0 + 16, 16'h0000, -1, 2'b00, -1, wcyc, ncyc);
        check("rr b done", 64'(frame_done), 64'd1);
        burst("sof own", 1'b1, B1 + 16, 16'h0000, 5, 2'b11, -1, wcyc, ncyc);
        check("sof own no done", 64'(frame_done), 64'd0);
        burst("rr d", 1'b0, B0, 16'h0000, -1, 2'b00, -1, wcyc, ncyc);
        burst("sof other", 1'b1, B1, 16'h0000, 4, 2'b01, -1, wcyc, ncyc);
        burst("after sof", 1'b0, B0, 16'h0000, -1, 2'b00, 8, wcyc, ncyc);
        check("en low cycles", 64'(ncyc), 64'd16);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("en low write", 64'(bus.avm_write), 64'd0);
            check("en low busy", 64'(busy), 64'd0);
        end

        en = 1'b1;
        wcyc = 0;
        while (!bus.avm_write && wcyc < 20) begin
            @(negedge clk); #1;
            wcyc++;
        end
        check("resume latency", 64'(wcyc), 64'd1);
        check("resume addr", 64'(bus.avm_address), 64'(B1 + 16));
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst write", 64'(bus.avm_write), 64'd0);
        check("async rst rq_rd", 64'(rq_rd), 64'd0);
        check("async rst busy", 64'(busy), 64'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;

        burst("post rst", 1'b0, B0, 16'h0000, -1, 2'b00, -1, wcyc, ncyc);
        check("post rst latency", 64'(wcyc), 64'd1);
        rq_req = 2'b00;
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
